ir_fetch_pipe: RTL and testbench
================================

Name: ir_fetch_pipe

Overview:
- Instruction-fetch and instruction-register pipeline for the 8-bit pipelined processor.
- Drives the instruction memory address and fetches one byte-wide instruction per cycle.
- Shifts each instruction through ir1 -> ir2 -> ir3 -> ir4 and supplies ir2/ir3/ir4 to the pipeline control unit.
- Consumes that unit's branchctrl/PCSel outputs to redirect the PC, squash wrong-path instructions, and insert bubbles on memory wait or stall.

Parameters:
- PC_W, 8, width of program counter and instruction memory address.
- RESET_PC, 8'h00, PC value loaded on reset.
- NOP_INSTR, 8'h0A, bubble/squash encoding (opcode 4'b1010, register fields 00).
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- imem_addr  out  PC_W  instruction memory address; equals the pc register.
- imem_req  out  1  fetch request; combinational = reset_n & branchctrl & ~PCSel_taken & ~stall (see Behaviour).
- imem_rdata  in  8  instruction byte returned in the same cycle as the request.
- imem_ready  in  1  imem_rdata valid this cycle; 0 = memory wait.
- branchctrl  in  1  from control unit; 0 = branch taken, flush.
- PCSel  in  1  from control unit; 0 = load branch_target into the PC.
- branch_target  in  PC_W  computed branch destination (ALU result).
- stall  in  1  hold the front end (pc, ir1, ir2) this cycle.
- ir1, ir2, ir3, ir4  out  8 each  pipeline instruction registers.
- pc2, pc3  out  PC_W each  fetch PC of the instructions in ir2/ir3, used by the branch offset path.
- retire_count  out  CNT_W  count of non-NOP instructions leaving ir4.

Behaviour:
- Reset (reset_n=0, asynchronous, any time including mid-fetch):
  - pc=RESET_PC; pc1/pc2/pc3=RESET_PC; ir1..ir4=NOP_INSTR; retire_count=0.
  - imem_req=0; all pending fetch data is discarded.
- taken = ~branchctrl | ~PCSel. Both are asserted together by the control unit; either alone is treated as a taken branch.
- Priority per rising edge: reset > taken > stall > memory wait > normal.
- Taken (flush):
  - pc <= branch_target.
  - ir1, ir2, ir3, ir4 <= NOP_INSTR; pc1..pc3 <= branch_target.
  - imem_rdata this cycle is ignored and imem_req is 0.
  - The first target instruction appears in ir1 at the edge after the flush edge.
- Stall (no taken):
  - pc, ir1, pc1, ir2, pc2 hold.
  - ir3 <= NOP_INSTR (bubble); ir4 <= ir3; imem_req=0.
- Memory wait (imem_ready=0, no stall, no taken):
  - pc holds; ir1 <= NOP_INSTR.
  - ir2 <= ir1, ir3 <= ir2, ir4 <= ir3; pc2 <= pc1, pc3 <= pc2.
- Normal (imem_ready=1):
  - ir1 <= imem_rdata; pc1 <= pc; pc <= pc + 1.
  - The PC increment wraps modulo 2^PC_W (8'hFF -> 8'h00).
  - Downstream shifts as in memory wait.
- Fetch latency: instruction at address A is visible on ir1 one edge after the fetch, ir2 after 2 edges, ir3 after 3, ir4 after 4.
- retire_count:
  - Increments by 1 on each edge where ir4 != NOP_INSTR and reset is inactive, including flush and stall edges.
  - Wraps at 2^CNT_W.
  - Instructions squashed by a flush never reach ir4 and are not counted.
- Simultaneous taken and stall: taken wins, and stall is ignored that cycle.
- Simultaneous taken and imem_ready=1: fetched data is dropped.
- No X may propagate to ir* from imem_rdata when imem_ready=0.

Test Plan:
- Reset release with memory returning 8'h41,8'h56,8'h08 at addresses 0,1,2 and imem_ready=1 -> after 4 edges ir4=8'h41, ir3=8'h56, ir2=8'h08, imem_addr=8'h04, retire_count=1.
- pc=8'hFF, imem_ready=1 for 2 cycles -> imem_addr goes 8'hFF, 8'h00, 8'h01; pc1 captures 8'hFF then 8'h00.
- In a full pipe, drive branchctrl=0, PCSel=0, branch_target=8'h20 for one cycle -> next edge ir1..ir4=8'h0A, imem_addr=8'h20; following edge ir1=mem[8'h20]; retire_count stops advancing while the NOPs drain.
- stall=1 for 2 cycles mid-stream -> pc/ir1/ir2 frozen, ir3 shows 8'h0A twice, ir4 receives one old ir3 then a bubble; resume with no lost or duplicated instruction.
- imem_ready=0 for 3 cycles -> three 8'h0A bubbles enter ir1, pc frozen; taken asserted on the 2nd wait cycle -> redirect to branch_target and full squash.
- Assert reset_n=0 asynchronously between edges mid-flush -> all outputs return to reset values immediately; fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/ir_fetch_pipe.sv
// Instruction fetch and IR1..IR4 shift pipeline for the 8-bit pipelined core.
// Handles branch redirect/squash, front-end stall bubbles and memory-wait bubbles.
module ir_fetch_pipe #(
  parameter int          PC_W      = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [7:0]  NOP_INSTR = 8'h0A,
  parameter int          CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  output logic [PC_W-1:0]  imem_addr,
  output logic             imem_req,
  input  logic [7:0]       imem_rdata,
  input  logic             imem_ready,
  input  logic             branchctrl,
  input  logic             PCSel,
  input  logic [PC_W-1:0]  branch_target,
  input  logic             stall,
  output logic [7:0]       ir1,
  output logic [7:0]       ir2,
  output logic [7:0]       ir3,
  output logic [7:0]       ir4,
  output logic [PC_W-1:0]  pc2,
  output logic [PC_W-1:0]  pc3,
  output logic [CNT_W-1:0] retire_count
);

  // Fetch handshake: imem_req is high whenever the front end can accept a byte;
  // a byte is consumed on an edge only when imem_req and imem_ready are both high.
  // imem_rdata is never looked at otherwise, so garbage/X cannot enter ir1.
  logic             taken;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  pc1_q, pc1_d;
  logic [PC_W-1:0]  pc2_q, pc2_d;
  logic [PC_W-1:0]  pc3_q, pc3_d;
  logic [7:0]       ir1_q, ir1_d;
  logic [7:0]       ir2_q, ir2_d;
  logic [7:0]       ir3_q, ir3_d;
  logic [7:0]       ir4_q, ir4_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Either control line alone low is treated as a taken branch.
  assign taken    = ~branchctrl | ~PCSel;
  assign imem_req = reset_n & ~taken & ~stall;

  always_comb begin
    pc_d  = pc_q;
    pc1_d = pc1_q;
    pc2_d = pc2_q;
    pc3_d = pc3_q;
    ir1_d = ir1_q;
    ir2_d = ir2_q;
    ir3_d = ir3_q;
    ir4_d = ir4_q;
    if (taken) begin
      pc_d  = branch_target;
      pc1_d = branch_target;
      pc2_d = branch_target;
      pc3_d = branch_target;
      ir1_d = NOP_INSTR;
      ir2_d = NOP_INSTR;
      ir3_d = NOP_INSTR;
      ir4_d = NOP_INSTR;
    end else if (stall) begin
      // Front end holds; a bubble enters ir3 while ir3 drains into ir4.
      ir3_d = NOP_INSTR;
      ir4_d = ir3_q;
    end else begin
      ir2_d = ir1_q;
      ir3_d = ir2_q;
      ir4_d = ir3_q;
      pc2_d = pc1_q;
      pc3_d = pc2_q;
      if (imem_ready) begin
        ir1_d = imem_rdata;
        pc1_d = pc_q;
        pc_d  = pc_q + PC_W'(1);
      end else begin
        ir1_d = NOP_INSTR;
      end
    end
  end

  // Counted as an instruction lands in ir4; squashed ones never get there.
  always_comb begin
    cnt_d = cnt_q;
    if (ir4_d != NOP_INSTR) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q  <= RESET_PC;
      pc1_q <= RESET_PC;
      pc2_q <= RESET_PC;
      pc3_q <= RESET_PC;
      ir1_q <= NOP_INSTR;
      ir2_q <= NOP_INSTR;
      ir3_q <= NOP_INSTR;
      ir4_q <= NOP_INSTR;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      pc1_q <= pc1_d;
      pc2_q <= pc2_d;
      pc3_q <= pc3_d;
      ir1_q <= ir1_d;
      ir2_q <= ir2_d;
      ir3_q <= ir3_d;
      ir4_q <= ir4_d;
      cnt_q <= cnt_d;
    end
  end

  assign imem_addr    = pc_q;
  assign ir1          = ir1_q;
  assign ir2          = ir2_q;
  assign ir3          = ir3_q;
  assign ir4          = ir4_q;
  assign pc2          = pc2_q;
  assign pc3          = pc3_q;
  assign retire_count = cnt_q;

endmodule

// File: tb/tb_ir_fetch_pipe.sv
// Directed bench for ir_fetch_pipe: reset, fill, stall, flush, memory wait,
// taken+stall, PC wrap and asynchronous reset mid-flush.
module tb_ir_fetch_pipe;

  logic        clock;
  logic        reset_n;
  logic [7:0]  imem_addr;
  logic        imem_req;
  logic [7:0]  imem_rdata;
  logic        imem_ready;
  logic        branchctrl;
  logic        PCSel;
  logic [7:0]  branch_target;
  logic        stall;
  logic [7:0]  ir1, ir2, ir3, ir4;
  logic [7:0]  pc2, pc3;
  logic [15:0] retire_count;

  logic [7:0]  mem [256];
  logic        rdata_garbage;
  int          n_checks;
  int          n_errors;

  ir_fetch_pipe dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .imem_addr     (imem_addr),
    .imem_req      (imem_req),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .branchctrl    (branchctrl),
    .PCSel         (PCSel),
    .branch_target (branch_target),
    .stall         (stall),
    .ir1           (ir1),
    .ir2           (ir2),
    .ir3           (ir3),
    .ir4           (ir4),
    .pc2           (pc2),
    .pc3           (pc3),
    .retire_count  (retire_count)
  );

  // Memory model: combinational read; garbage byte while the bench signals a wait.
  assign imem_rdata = rdata_garbage ? 8'hEE : mem[imem_addr];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 8'h40);
    mem[0]        = 8'h41;
    mem[1]        = 8'h56;
    mem[2]        = 8'h08;
    reset_n       = 1'b0;
    imem_ready    = 1'b1;
    branchctrl    = 1'b1;
    PCSel         = 1'b1;
    branch_target = 8'h00;
    stall         = 1'b0;
    rdata_garbage = 1'b0;

    // Reset state
    #12;
    chk("rst_addr", 16'(imem_addr), 16'h00);
    chk("rst_req", 16'(imem_req), 16'h0);
    chk("rst_ir1", 16'(ir1), 16'h0A);
    chk("rst_ir4", 16'(ir4), 16'h0A);
    chk("rst_pc3", 16'(pc3), 16'h00);
    chk("rst_cnt", retire_count, 16'h0);
    reset_n = 1'b1;
    #1;
    chk("run_req", 16'(imem_req), 16'h1);

    // Fill: four edges from reset
    step(); step(); step(); step();
    chk("fill_ir4", 16'(ir4), 16'h41);
    chk("fill_ir3", 16'(ir3), 16'h56);
    chk("fill_ir2", 16'(ir2), 16'h08);
    chk("fill_ir1", 16'(ir1), 16'h43);
    chk("fill_addr", 16'(imem_addr), 16'h04);
    chk("fill_cnt", retire_count, 16'h1);
    chk("fill_pc2", 16'(pc2), 16'h02);

    // Stall two cycles
    stall = 1'b1;
    #1;
    chk("stall_req", 16'(imem_req), 16'h0);
    step();
    chk("st1_addr", 16'(imem_addr), 16'h04);
    chk("st1_ir1", 16'(ir1), 16'h43);
    chk("st1_ir2", 16'(ir2), 16'h08);
    chk("st1_ir3", 16'(ir3), 16'h0A);
    chk("st1_ir4", 16'(ir4), 16'h56);
    chk("st1_cnt", retire_count, 16'h2);
    step();
    chk("st2_ir3", 16'(ir3), 16'h0A);
    chk("st2_ir4", 16'(ir4), 16'h0A);
    chk("st2_ir2", 16'(ir2), 16'h08);
    chk("st2_cnt", retire_count, 16'h2);
    stall = 1'b0;
    step();
    chk("rs1_ir1", 16'(ir1), 16'h44);
    chk("rs1_ir3", 16'(ir3), 16'h08);
    chk("rs1_ir4", 16'(ir4), 16'h0A);
    step();
    chk("rs2_ir4", 16'(ir4), 16'h08);
    chk("rs2_ir3", 16'(ir3), 16'h43);
    chk("rs2_pc2", 16'(pc2), 16'h04);
    chk("rs2_pc3", 16'(pc3), 16'h03);
    chk("rs2_cnt", retire_count, 16'h3);

    // Branch flush to 0x20
    branchctrl    = 1'b0;
    PCSel         = 1'b0;
    branch_target = 8'h20;
    #1;
    chk("br_req", 16'(imem_req), 16'h0);
    step();
    branchctrl = 1'b1;
    PCSel      = 1'b1;
    chk("fl_addr", 16'(imem_addr), 16'h20);
    chk("fl_irs", {ir1, ir2}, 16'h0A0A);
    chk("fl_ir34", {ir3, ir4}, 16'h0A0A);
    chk("fl_pc2", 16'(pc2), 16'h20);
    chk("fl_cnt", retire_count, 16'h3);
    step();
    chk("tg_ir1", 16'(ir1), 16'h60);
    chk("tg_addr", 16'(imem_addr), 16'h21);
    step(); step();
    chk("drain_cnt", retire_count, 16'h3);
    chk("drain_ir3", 16'(ir3), 16'h60);
    chk("drain_pc3", 16'(pc3), 16'h20);
    step();
    chk("tg_ir4", 16'(ir4), 16'h60);
    chk("tg_cnt", retire_count, 16'h4);

    // Memory wait three cycles with garbage data
    imem_ready    = 1'b0;
    rdata_garbage = 1'b1;
    step();
    chk("w1_ir1", 16'(ir1), 16'h0A);
    chk("w1_ir2", 16'(ir2), 16'h63);
    chk("w1_addr", 16'(imem_addr), 16'h24);
    step();
    chk("w2_ir1", 16'(ir1), 16'h0A);
    step();
    chk("w3_ir1", 16'(ir1), 16'h0A);
    chk("w3_ir4", 16'(ir4), 16'h63);
    chk("w3_addr", 16'(imem_addr), 16'h24);
    chk("w3_cnt", retire_count, 16'h7);
    imem_ready    = 1'b1;
    rdata_garbage = 1'b0;
    step();
    chk("wr_ir1", 16'(ir1), 16'h64);
    chk("wr_addr", 16'(imem_addr), 16'h25);
    chk("wr_ir4", 16'(ir4), 16'h0A);

    // Wait with taken on the second wait cycle
    imem_ready    = 1'b0;
    rdata_garbage = 1'b1;
    step();
    chk("wt1_ir2", 16'(ir2), 16'h64);
    branchctrl    = 1'b0;
    PCSel         = 1'b0;
    branch_target = 8'h40;
    step();
    branchctrl = 1'b1;
    PCSel      = 1'b1;
    chk("wt2_addr", 16'(imem_addr), 16'h40);
    chk("wt2_ir12", {ir1, ir2}, 16'h0A0A);
    chk("wt2_cnt", retire_count, 16'h7);
    step();
    chk("wt3_ir1", 16'(ir1), 16'h0A);
    chk("wt3_addr", 16'(imem_addr), 16'h40);
    imem_ready    = 1'b1;
    rdata_garbage = 1'b0;
    step();
    chk("wt4_ir1", 16'(ir1), 16'h80);
    chk("wt4_addr", 16'(imem_addr), 16'h41);

    // Taken together with stall: taken wins; then PC wrap from 0xFF
    branchctrl    = 1'b0;
    PCSel         = 1'b1;
    stall         = 1'b1;
    branch_target = 8'hFF;
    step();
    branchctrl = 1'b1;
    stall      = 1'b0;
    chk("ts_addr", 16'(imem_addr), 16'hFF);
    chk("ts_ir1", 16'(ir1), 16'h0A);
    step();
    chk("wrap0_addr", 16'(imem_addr), 16'h00);
    chk("wrap0_ir1", 16'(ir1), 16'h3F);
    step();
    chk("wrap1_addr", 16'(imem_addr), 16'h01);
    chk("wrap1_pc2", 16'(pc2), 16'hFF);
    step();
    chk("wrap2_pc2", 16'(pc2), 16'h00);
    chk("wrap2_ir2", 16'(ir2), 16'h41);
    chk("wrap2_cnt", retire_count, 16'h7);

    // Asynchronous reset between edges while a flush is pending
    branchctrl    = 1'b0;
    PCSel         = 1'b0;
    branch_target = 8'h30;
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_addr", 16'(imem_addr), 16'h00);
    chk("ar_ir1", 16'(ir1), 16'h0A);
    chk("ar_ir3", 16'(ir3), 16'h0A);
    chk("ar_cnt", retire_count, 16'h0);
    chk("ar_req", 16'(imem_req), 16'h0);
    branchctrl = 1'b1;
    PCSel      = 1'b1;
    #1;
    reset_n = 1'b1;
    step();
    chk("ar_rs_ir1", 16'(ir1), 16'h41);
    chk("ar_rs_addr", 16'(imem_addr), 16'h01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
